// File: rtl/weight_load_ctrl_pkg.sv
// Shared widths and FSM encoding for the weight-load path.
// The weight-load pipeline register imports the same constants.
package weight_load_ctrl_pkg;
  localparam int NROW    = 4;
  localparam int ROW_W   = 2;
  localparam int SHAMT_W = 5;
  localparam int WORD_W  = 32;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;
endpackage

// File: rtl/weight_load_ctrl.sv
// Weight-load sequencer: reads NROW weight words from BASE_ADDR and emits
// one registered load beat per row toward the MAC array weight register.
module weight_load_ctrl
  import weight_load_ctrl_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               START,
  input  logic [ADDR_W-1:0]  BASE_ADDR,
  input  logic [SHAMT_W-1:0] SHAMT_IN,
  input  logic               STALL,
  output logic               MEM_RE,
  output logic [ADDR_W-1:0]  MEM_ADDR,
  input  logic [WORD_W-1:0]  MEM_RDATA,
  output logic               WLoad,
  output logic [WORD_W-1:0]  WDATA,
  output logic [SHAMT_W-1:0] shamt,
  output logic [ROW_W-1:0]   WROW,
  output logic               BUSY,
  output logic               DONE
);

  state_t             state, state_nxt;
  logic [ADDR_W-1:0]  base;
  logic [SHAMT_W-1:0] shamt_l;
  logic [ROW_W-1:0]   cnt;
  logic               rd_v;
  logic [ROW_W-1:0]   rd_row;
  logic               start_acc, issue, last_issue, last_ret;

  // BUSY stays high through the DONE cycle, so it also blocks a START there
  assign start_acc  = (state == IDLE) && START && !BUSY;
  assign issue      = (state == ISSUE) && !STALL;
  assign last_issue = issue && (cnt == ROW_W'(NROW-1));
  assign last_ret   = rd_v && (rd_row == ROW_W'(NROW-1));

  assign MEM_RE   = issue;
  assign MEM_ADDR = (state == ISSUE) ? base + ADDR_W'(cnt) : '0;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_acc)  state_nxt = ISSUE;
      ISSUE:   if (last_issue) state_nxt = DRAIN;
      DRAIN:   if (last_ret)   state_nxt = IDLE;
      default:                 state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= IDLE;
      base    <= '0;
      shamt_l <= '0;
      cnt     <= '0;
      rd_v    <= 1'b0;
      rd_row  <= '0;
      WLoad   <= 1'b0;
      WDATA   <= '0;
      shamt   <= '0;
      WROW    <= '0;
      BUSY    <= 1'b0;
      DONE    <= 1'b0;
    end else begin
      state <= state_nxt;
      if (start_acc) begin
        base    <= BASE_ADDR;
        shamt_l <= SHAMT_IN;
        cnt     <= '0;
      end else if (issue) begin
        cnt <= cnt + 1'b1;
      end
      // one-stage return tracker matching the 1-cycle memory latency
      rd_v <= issue;
      if (issue) rd_row <= cnt;
      WLoad <= rd_v;
      if (rd_v) begin
        WDATA <= MEM_RDATA;
        WROW  <= rd_row;
        shamt <= shamt_l;
      end
      DONE <= last_ret;
      if (start_acc)  BUSY <= 1'b1;
      else if (DONE)  BUSY <= 1'b0;
    end
  end

endmodule

// File: tb/tb_weight_load_ctrl.sv
// Directed per-cycle vectors for weight_load_ctrl; each record holds the
// inputs for one cycle and the outputs expected within that cycle.
module tb_weight_load_ctrl;
  import weight_load_ctrl_pkg::*;

  logic        CLK = 1'b0;
  logic        RST, START, STALL;
  logic [7:0]  BASE_ADDR;
  logic [4:0]  SHAMT_IN;
  logic        MEM_RE;
  logic [7:0]  MEM_ADDR;
  logic [31:0] MEM_RDATA;
  logic        WLoad;
  logic [31:0] WDATA;
  logic [4:0]  shamt;
  logic [1:0]  WROW;
  logic        BUSY, DONE;

  int total = 0;
  int bad   = 0;
  logic [7:0] wb;

  typedef struct {
    bit rst, start, stall;
    logic [7:0] base; logic [4:0] sh;
    bit chk, zero;
    bit re; logic [7:0] addr;
    bit wl; logic [1:0] row; logic [31:0] wd; logic [4:0] esh;
    bit busy, done;
  } vec_t;

  vec_t tbl[$];

  weight_load_ctrl #(.ADDR_W(8)) dut (
    .CLK(CLK), .RST(RST), .START(START), .BASE_ADDR(BASE_ADDR),
    .SHAMT_IN(SHAMT_IN), .STALL(STALL), .MEM_RE(MEM_RE), .MEM_ADDR(MEM_ADDR),
    .MEM_RDATA(MEM_RDATA), .WLoad(WLoad), .WDATA(WDATA), .shamt(shamt),
    .WROW(WROW), .BUSY(BUSY), .DONE(DONE)
  );

  always #5 CLK = ~CLK;

  // memory model: word = 0xA0A00000 | addr, one cycle after the read
  always @(posedge CLK)
    MEM_RDATA <= MEM_RE ? {24'hA0A000, MEM_ADDR} : 32'hDEAD_BEEF;

  function automatic vec_t mk(bit rst, bit start, bit stall, logic [7:0] base,
                              logic [4:0] sh, bit re, logic [7:0] addr, bit wl,
                              logic [1:0] row, logic [4:0] esh, bit busy, bit done);
    vec_t v;
    v.rst = rst; v.start = start; v.stall = stall; v.base = base; v.sh = sh;
    v.chk = 1'b1; v.zero = 1'b0;
    v.re = re; v.addr = addr; v.wl = wl; v.row = row; v.esh = esh;
    v.wd = {24'hA0A000, 8'(wb + {6'd0, row})};
    v.busy = busy; v.done = done;
    return v;
  endfunction

  // every output must be exactly zero
  function automatic vec_t mkz(bit chk, bit rst, bit start, logic [7:0] base, logic [4:0] sh);
    vec_t v;
    v = mk(rst, start, 1'b0, base, sh, 0, 0, 0, 0, 0, 0, 0);
    v.chk = chk; v.zero = 1'b1;
    return v;
  endfunction

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %h want %h", name, $time, act, exp);
    end
  endtask

  task automatic step(input vec_t v);
    RST = v.rst; START = v.start; STALL = v.stall;
    BASE_ADDR = v.base; SHAMT_IN = v.sh;
    @(negedge CLK);
    if (v.chk) begin
      cmp("mem_re", 32'(MEM_RE), 32'(v.re));
      cmp("wload",  32'(WLoad),  32'(v.wl));
      cmp("busy",   32'(BUSY),   32'(v.busy));
      cmp("done",   32'(DONE),   32'(v.done));
      if (v.zero) begin
        cmp("mem_addr_zero", 32'(MEM_ADDR), 0);
        cmp("wdata_zero",    WDATA,         0);
        cmp("wrow_zero",     32'(WROW),     0);
        cmp("shamt_zero",    32'(shamt),    0);
      end else begin
        if (v.re) cmp("mem_addr", 32'(MEM_ADDR), 32'(v.addr));
        if (v.wl) begin
          cmp("wdata", WDATA,      v.wd);
          cmp("wrow",  32'(WROW),  32'(v.row));
          cmp("shamt", 32'(shamt), 32'(v.esh));
        end
      end
    end
    @(posedge CLK); #1;
  endtask

  initial begin
    RST = 1'b1; START = 1'b0; STALL = 1'b0; BASE_ADDR = '0; SHAMT_IN = '0;
    @(posedge CLK); #1;

    // reset held with START asserted
    tbl.push_back(mkz(0, 1, 1, 8'h33, 5'd9));
    tbl.push_back(mkz(1, 1, 1, 8'h33, 5'd9));
    tbl.push_back(mkz(1, 0, 0, 8'h00, 5'd0));

    // basic sequence: base 0x10, shamt 5
    wb = 8'h10;
    tbl.push_back(mk(0,1,0,8'h10,5,  0,0,     0,0,0, 0,0));
    tbl.push_back(mk(0,0,0,0,0,      1,8'h10, 0,0,0, 1,0));
    tbl.push_back(mk(0,0,0,0,0,      1,8'h11, 0,0,0, 1,0));
    tbl.push_back(mk(0,0,0,0,0,      1,8'h12, 1,0,5, 1,0));
    tbl.push_back(mk(0,0,0,0,0,      1,8'h13, 1,1,5, 1,0));
    tbl.push_back(mk(0,0,0,0,0,      0,0,     1,2,5, 1,0));
    tbl.push_back(mk(0,0,0,0,0,      0,0,     1,3,5, 1,1));
    tbl.push_back(mk(0,0,0,0,0,      0,0,     0,0,0, 0,0));

    // stall in cycles 2-3
    tbl.push_back(mk(0,1,0,8'h10,5,  0,0,     0,0,0, 0,0));
    tbl.push_back(mk(0,0,0,0,0,      1,8'h10, 0,0,0, 1,0));
    tbl.push_back(mk(0,0,1,0,0,      0,0,     0,0,0, 1,0));
    tbl.push_back(mk(0,0,1,0,0,      0,0,     1,0,5, 1,0));
    tbl.push_back(mk(0,0,0,0,0,      1,8'h11, 0,0,0, 1,0));
    tbl.push_back(mk(0,0,0,0,0,      1,8'h12, 0,0,0, 1,0));
    tbl.push_back(mk(0,0,0,0,0,      1,8'h13, 1,1,5, 1,0));
    tbl.push_back(mk(0,0,0,0,0,      0,0,     1,2,5, 1,0));
    tbl.push_back(mk(0,0,0,0,0,      0,0,     1,3,5, 1,1));
    tbl.push_back(mk(0,0,0,0,0,      0,0,     0,0,0, 0,0));

    // address wrap: base 0xFE, shamt 31
    wb = 8'hFE;
    tbl.push_back(mk(0,1,0,8'hFE,31, 0,0,     0,0,0,  0,0));
    tbl.push_back(mk(0,0,0,0,0,      1,8'hFE, 0,0,0,  1,0));
    tbl.push_back(mk(0,0,0,0,0,      1,8'hFF, 0,0,0,  1,0));
    tbl.push_back(mk(0,0,0,0,0,      1,8'h00, 1,0,31, 1,0));
    tbl.push_back(mk(0,0,0,0,0,      1,8'h01, 1,1,31, 1,0));
    tbl.push_back(mk(0,0,0,0,0,      0,0,     1,2,31, 1,0));
    tbl.push_back(mk(0,0,0,0,0,      0,0,     1,3,31, 1,1));
    tbl.push_back(mk(0,0,0,0,0,      0,0,     0,0,0,  0,0));

    foreach (tbl[i]) step(tbl[i]);

    // START during busy (cycles 2 and 6) ignored; cycle 7 accepted
    wb = 8'h10;
    step(mk(0,1,0,8'h10,7,  0,0,     0,0,0, 0,0));
    step(mk(0,0,0,0,0,      1,8'h10, 0,0,0, 1,0));
    step(mk(0,1,0,8'h40,9,  1,8'h11, 0,0,0, 1,0));
    step(mk(0,0,0,0,0,      1,8'h12, 1,0,7, 1,0));
    step(mk(0,0,0,0,0,      1,8'h13, 1,1,7, 1,0));
    step(mk(0,0,0,0,0,      0,0,     1,2,7, 1,0));
    step(mk(0,1,0,8'h40,9,  0,0,     1,3,7, 1,1));
    step(mk(0,1,0,8'h20,3,  0,0,     0,0,0, 0,0));
    wb = 8'h20;
    step(mk(0,0,0,0,0,      1,8'h20, 0,0,0, 1,0));
    step(mk(0,0,0,0,0,      1,8'h21, 0,0,0, 1,0));
    step(mk(0,0,0,0,0,      1,8'h22, 1,0,3, 1,0));
    step(mk(0,0,0,0,0,      1,8'h23, 1,1,3, 1,0));
    step(mk(0,0,0,0,0,      0,0,     1,2,3, 1,0));
    step(mk(0,0,0,0,0,      0,0,     1,3,3, 1,1));
    step(mk(0,0,0,0,0,      0,0,     0,0,0, 0,0));

    // reset in cycle 4, restart in cycle 6
    wb = 8'h10;
    step(mk(0,1,0,8'h10,5,  0,0,     0,0,0, 0,0));
    step(mk(0,0,0,0,0,      1,8'h10, 0,0,0, 1,0));
    step(mk(0,0,0,0,0,      1,8'h11, 0,0,0, 1,0));
    step(mk(0,0,0,0,0,      1,8'h12, 1,0,5, 1,0));
    step(mk(1,0,0,0,0,      1,8'h13, 1,1,5, 1,0));
    step(mkz(1, 0, 0, 8'h00, 5'd0));
    step(mkz(1, 0, 1, 8'h30, 5'd2));
    wb = 8'h30;
    step(mk(0,0,0,0,0,      1,8'h30, 0,0,0, 1,0));
    step(mk(0,0,0,0,0,      1,8'h31, 0,0,0, 1,0));
    step(mk(0,0,0,0,0,      1,8'h32, 1,0,2, 1,0));
    step(mk(0,0,0,0,0,      1,8'h33, 1,1,2, 1,0));
    step(mk(0,0,0,0,0,      0,0,     1,2,2, 1,0));
    step(mk(0,0,0,0,0,      0,0,     1,3,2, 1,1));
    step(mk(0,0,0,0,0,      0,0,     0,0,0, 0,0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
